// File: rtl/rr_onehot_scheduler_if.sv
// Handshake bundle between the requesters, the round-robin scheduler and the
// shared downstream port. The master modport is the scheduler's view.
interface rr_onehot_scheduler_if #(
  parameter int NumIn = 4
);
  localparam int IdxWidth = (NumIn == 1) ? 1 : $clog2(NumIn);

  logic [NumIn-1:0]    req_i;
  logic [NumIn-1:0]    gnt_o;
  logic [NumIn-1:0]    sel_o;
  logic [IdxWidth-1:0] idx_o;
  logic                valid_o;
  logic                ready_i;

  modport master (
    input  req_i,
    input  ready_i,
    output gnt_o,
    output sel_o,
    output idx_o,
    output valid_o
  );

  modport slave (
    output req_i,
    output ready_i,
    input  gnt_o,
    input  sel_o,
    input  idx_o,
    input  valid_o
  );
endinterface

// File: rtl/rr_onehot_scheduler.sv
// Round-robin scheduler: picks one active requester starting from a rotating
// pointer, holds the pick while the downstream stalls, and advances the
// pointer past the winner only when the handshake completes.
module rr_onehot_scheduler #(
  parameter int NumIn = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  rr_onehot_scheduler_if.master  bus
);
  localparam int IdxWidth = (NumIn == 1) ? 1 : $clog2(NumIn);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [NumIn-1:0]    sel_q, sel_d;

  logic [NumIn-1:0]    req_rot;
  logic                win_found;
  logic [IdxWidth-1:0] win_idx;
  logic [NumIn-1:0]    sel_arb;
  logic [NumIn-1:0]    sel;
  logic [NumIn-1:0]    gnt;
  logic [IdxWidth-1:0] idx;
  logic [IdxWidth-1:0] idx_inc;
  logic                valid;
  logic                hs;

  // Rotate the requests so the pointer position lands on bit 0; the first set
  // bit of the rotated vector is then the distance from the pointer to the winner.
  assign req_rot = NumIn'({bus.req_i, bus.req_i} >> rr_q);

  // Find the nearest request at or after the pointer and map it back to an index.
  always_comb begin
    int sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = 0;
    for (int j = 0; j < NumIn; j++) begin
      if (!win_found && req_rot[j]) begin
        win_found = 1'b1;
        sum       = int'(rr_q) + j;
        if (sum >= NumIn) begin
          sum = sum - NumIn;
        end
        win_idx = IdxWidth'(sum);
      end
    end
  end

  // One-hot decode of the arbitration winner.
  generate
    for (genvar gi = 0; gi < NumIn; gi++) begin : g_sel_arb
      assign sel_arb[gi] = win_found && (win_idx == IdxWidth'(gi));
    end
  endgenerate

  // Output logic: a held selection overrides live arbitration.
  always_comb begin
    sel   = (state_q == LOCK) ? sel_q : sel_arb;
    valid = |sel;
    hs    = valid & bus.ready_i;
    gnt   = hs ? sel : '0;
    idx   = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (sel[k]) begin
        idx = idx | IdxWidth'(k);
      end
    end
    // Explicit wrap so a non-power-of-two NumIn never reaches NumIn.
    idx_inc = (idx == IdxWidth'(NumIn - 1)) ? '0 : idx + IdxWidth'(1);
  end

  assign bus.sel_o   = sel;
  assign bus.gnt_o   = gnt;
  assign bus.idx_o   = idx;
  assign bus.valid_o = valid;

  // Next-state logic: lock on a stall, advance the pointer on a handshake; flush wins.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    if (flush_i) begin
      state_d = IDLE;
      rr_d    = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid && !bus.ready_i) begin
            state_d = LOCK;
            sel_d   = sel;
          end else if (hs) begin
            rr_d = idx_inc;
          end
        end
        LOCK: begin
          if (hs) begin
            state_d = IDLE;
            rr_d    = idx_inc;
            sel_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
    end
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  // The selection presented downstream is never more than one requester.
  sel_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(sel));

  // A held requester must keep its request up until it is granted.
  lock_req_held_a : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (state_q == LOCK) |-> |(bus.req_i & sel_q));
`endif
`endif

endmodule

// File: tb/tb_rr_onehot_scheduler.sv
// Bench for rr_onehot_scheduler: directed vector table on a 4-input instance,
// a wrap sequence on a 3-input instance, and random traffic against a model.
module tb_rr_onehot_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush4 = 1'b0;
  logic flush3 = 1'b0;

  always #5 clk = ~clk;

  rr_onehot_scheduler_if #(.NumIn(4)) bus4 ();
  rr_onehot_scheduler_if #(.NumIn(3)) bus3 ();

  rr_onehot_scheduler #(.NumIn(4)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush4),
    .bus     (bus4)
  );

  rr_onehot_scheduler #(.NumIn(3)) dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush3),
    .bus     (bus3)
  );

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic       flush;
    logic       rst;
    logic       chk;
    logic [3:0] sel;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic ready, input logic flush,
                              input logic rs, input logic chk, input logic [3:0] sel,
                              input logic [3:0] gnt, input logic [1:0] idx);
    vec_t v;
    v.req = req; v.ready = ready; v.flush = flush; v.rst = rs; v.chk = chk;
    v.sel = sel; v.gnt = gnt; v.idx = idx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] sel, input logic [3:0] gnt,
                        input logic [1:0] idx);
    check({tag, ".sel"},   32'(bus4.sel_o),   32'(sel));
    check({tag, ".gnt"},   32'(bus4.gnt_o),   32'(gnt));
    check({tag, ".idx"},   32'(bus4.idx_o),   32'(idx));
    check({tag, ".valid"}, 32'(bus4.valid_o), 32'(|sel));
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive4(input logic [3:0] req, input logic rdy, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus4.req_i   = req;
    bus4.ready_i = rdy;
    flush4       = fl;
    rst          = rs;
    @(negedge clk);
  endtask

  // Reference winner: scan from the pointer with modulo wrap; -1 if no request.
  function automatic int pick(input logic [3:0] req, input int n, input int ptr);
    for (int j = 0; j < n; j++) begin
      int p;
      p = (ptr + j) % n;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  initial begin
    logic [3:0] oh;
    logic [2:0] oh3;
    int         m_ptr;
    bit         m_lock;
    int         m_held;

    bus4.req_i   = '0;
    bus4.ready_i = 1'b0;
    bus3.req_i   = '0;
    bus3.ready_i = 1'b0;
    repeat (3) @(posedge clk);

    // ---------------- directed vector table (NumIn=4) ----------------
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0000, 2'd0));
    for (int i = 0; i < 8; i++) begin
      oh = 4'b0001 << (i % 4);
      vecs.push_back(mk(4'b1111, 1, 0, 0, 1, oh, oh, 2'(i % 4)));
    end
    vecs.push_back(mk(4'b0010, 1, 0, 0, 1, 4'b0010, 4'b0010, 2'd1));
    vecs.push_back(mk(4'b0011, 1, 0, 0, 1, 4'b0001, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b0011, 1, 0, 0, 1, 4'b0010, 4'b0010, 2'd1));
    vecs.push_back(mk(4'b1000, 1, 0, 0, 1, 4'b1000, 4'b1000, 2'd3));
    vecs.push_back(mk(4'b0110, 0, 0, 0, 1, 4'b0010, 4'b0000, 2'd1));
    vecs.push_back(mk(4'b0111, 0, 0, 0, 1, 4'b0010, 4'b0000, 2'd1));
    vecs.push_back(mk(4'b0111, 0, 0, 0, 1, 4'b0010, 4'b0000, 2'd1));
    vecs.push_back(mk(4'b0111, 1, 0, 0, 1, 4'b0010, 4'b0010, 2'd1));
    vecs.push_back(mk(4'b0110, 1, 0, 0, 1, 4'b0100, 4'b0100, 2'd2));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0000, 2'd0));
    end
    vecs.push_back(mk(4'b1111, 1, 0, 0, 1, 4'b1000, 4'b1000, 2'd3));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 1, 4'b0100, 4'b0000, 2'd2));
    vecs.push_back(mk(4'b1111, 0, 1, 0, 1, 4'b0100, 4'b0000, 2'd2));
    vecs.push_back(mk(4'b1111, 1, 0, 0, 1, 4'b0001, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 1, 4'b0100, 4'b0000, 2'd2));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mk(4'b1111, 1, 0, 0, 1, 4'b0001, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b0010, 1, 1, 0, 1, 4'b0010, 4'b0010, 2'd1));
    vecs.push_back(mk(4'b1111, 1, 0, 0, 1, 4'b0001, 4'b0001, 2'd0));

    foreach (vecs[i]) begin
      drive4(vecs[i].req, vecs[i].ready, vecs[i].flush, vecs[i].rst);
      $display("vec %0d req=%b rdy=%b fl=%b rst=%b sel=%b gnt=%b idx=%0d", i, vecs[i].req,
               vecs[i].ready, vecs[i].flush, vecs[i].rst, bus4.sel_o, bus4.gnt_o, bus4.idx_o);
      if (vecs[i].chk) check4($sformatf("vec%0d", i), vecs[i].sel, vecs[i].gnt, vecs[i].idx);
    end

    // ---------------- NumIn=3 pointer wrap ----------------
    drive4(4'b0000, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus3.req_i   = 3'b111;
      bus3.ready_i = 1'b1;
      @(negedge clk);
      oh3 = 3'b001 << (i % 3);
      $display("n3 %0d sel=%b gnt=%b idx=%0d", i, bus3.sel_o, bus3.gnt_o, bus3.idx_o);
      check($sformatf("n3_%0d.idx", i), 32'(bus3.idx_o), 32'(i % 3));
      check($sformatf("n3_%0d.gnt", i), 32'(bus3.gnt_o), 32'(oh3));
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      bus3.req_i = 3'b011;
      @(negedge clk);
      $display("n3 wrap %0d sel=%b idx=%0d", i, bus3.sel_o, bus3.idx_o);
      check($sformatf("n3_wrap%0d.idx", i), 32'(bus3.idx_o), 32'(i));
      check($sformatf("n3_wrap%0d.valid", i), 32'(bus3.valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    bus3.req_i   = '0;
    bus3.ready_i = 1'b0;

    // ---------------- random traffic vs. reference model ----------------
    drive4(4'b0000, 1, 0, 1);
    m_ptr  = 0;
    m_lock = 0;
    m_held = 0;
    for (int t = 0; t < 400; t++) begin
      logic [3:0] req;
      logic [3:0] e_sel;
      logic [3:0] e_gnt;
      logic [1:0] e_idx;
      logic       rdy;
      logic       fl;
      logic       rs;
      int         cur;
      bit         hs;
      req = 4'($urandom_range(0, 15));
      if (m_lock) req[m_held] = 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      rs  = ($urandom_range(0, 63) == 0);
      drive4(req, rdy, fl, rs);
      cur   = m_lock ? m_held : pick(req, 4, m_ptr);
      e_sel = (cur >= 0) ? (4'b0001 << cur) : 4'b0000;
      e_idx = (cur >= 0) ? 2'(cur) : 2'd0;
      hs    = (cur >= 0) && rdy;
      e_gnt = hs ? e_sel : 4'b0000;
      $display("rnd %0d req=%b rdy=%b fl=%b rst=%b sel=%b gnt=%b idx=%0d", t, req, rdy, fl, rs,
               bus4.sel_o, bus4.gnt_o, bus4.idx_o);
      if (!rs) check4($sformatf("rnd%0d", t), e_sel, e_gnt, e_idx);
      if (rs || fl) begin
        m_ptr  = 0;
        m_lock = 0;
      end else if (m_lock) begin
        if (hs) begin
          m_lock = 0;
          m_ptr  = (m_held + 1) % 4;
        end
      end else if (cur >= 0 && !rdy) begin
        m_lock = 1;
        m_held = cur;
      end else if (hs) begin
        m_ptr = (cur + 1) % 4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_onehot_scheduler.md
Name: rr_onehot_scheduler

Overview:
- Round-robin scheduler that shares one downstream valid/ready port between NumIn requesters.
- Each cycle it selects one active request, starting the search at a rotating priority pointer. It presents the winner as a one-hot select vector and as a binary index; the binary index is the one-hot select encoded to binary.
- The selection is locked while the downstream stalls. The pointer advances only on a completed handshake.
- It sits in front of shared muxes and resources, which use the binary index as the mux select and the one-hot grant as the per-requester acknowledge.

Parameters:
- NumIn, 4, number of requesters; legal range is 1 or more, and it does not have to be a power of two.
- IdxWidth, NumIn==1 ? 1 : $clog2(NumIn), width of the binary index; derived, do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of the pointer and the lock, same effect as rst_i.
- req_i  in  NumIn  per-requester request level.
- gnt_o  out  NumIn  one-hot acknowledge; bit k is high only in the handshake cycle of requester k.
- sel_o  out  NumIn  one-hot current selection; all zero when no requester is selected.
- idx_o  out  IdxWidth  binary encoding of sel_o; 0 when sel_o is zero.
- valid_o  out  1  downstream valid; equals |sel_o.
- ready_i  in  1  downstream ready.

Behaviour:
- State:
  - rr_q [IdxWidth], the priority pointer, in range 0..NumIn-1.
  - lock_q [1], set while a selection is held.
  - sel_q [NumIn], the held one-hot selection.
- Reset (rst_i=1 at an edge): rr_q=0, lock_q=0, sel_q=0.
  - Outputs while rst_i is high are combinational from the cleared state and req_i. The bench checks only after the reset edge: the first cycle after reset arbitrates from pointer 0.
- Unlocked selection (combinational):
  - Winner = first k with req_i[k]=1, scanning k = rr_q, rr_q+1, ..., NumIn-1, 0, ..., rr_q-1.
  - sel_o = one-hot of the winner, or zero if req_i == 0.
  - Zero-cycle latency from req_i to valid_o.
- Locked (lock_q=1): sel_o = sel_q, regardless of the other req_i bits.
- Handshake: hs = valid_o & ready_i.
  - gnt_o = sel_o when hs=1, else 0.
- idx_o: binary of sel_o.
  - No more than one bit of sel_o is ever set. Add a simulation-only assertion, disabled by COMMON_CELLS_ASSERTS_OFF.
- FSM: two states.
  - IDLE (lock_q=0):
    - valid_o & !ready_i -> LOCK, capturing sel_q = sel_o.
    - hs -> stay in IDLE and set rr_q = winner+1, wrapping to 0 when winner = NumIn-1.
    - no request -> IDLE, rr_q unchanged.
  - LOCK (lock_q=1):
    - hs -> IDLE, rr_q = held index+1 with the same wrap, sel_q = 0.
    - otherwise stay in LOCK.
- Protocol rules on the requester side:
  - A requester that is selected keeps req_i high until it receives gnt_o. Add a simulation-only assertion: in LOCK, req_i & sel_q must be nonzero.
  - If the requester drops anyway, the lock still holds and valid_o stays high; no recovery beyond flush_i.
- Pointer wrap for a non-power-of-two NumIn: rr_q never takes a value of NumIn or above. The increment is compared against NumIn-1, not allowed to overflow naturally.
- flush_i=1 at an edge:
  - rr_q=0, lock_q=0, sel_q=0.
  - Takes priority over a simultaneous handshake update; gnt_o may still pulse in that cycle.
- rst_i asserted mid-LOCK: the lock is dropped and the held selection is lost; the next cycle arbitrates from 0.
- NumIn=1:
  - idx_o is always 0, rr_q stays 0, sel_o = req_i[0] (or sel_q when locked).
- Fairness: any requester held high is granted within NumIn handshakes.
- Target implementation size: about 150-250 lines of RTL.

Test Plan:
- Reset, then NumIn=4 with req_i=4'b1111 and ready_i=1 held for 8 cycles -> gnt_o = 0001, 0010, 0100, 1000, 0001, ...; idx_o = 0, 1, 2, 3, 0, ...
- After a grant to requester 1 (rr_q=2), apply req_i=4'b0011 -> winner is 0 via wrap, then 1 next; idx_o = 0, 1.
- Lock: req_i=4'b0110 with ready_i=0 for 3 cycles -> sel_o=0010 and valid_o=1 stable, gnt_o=0. In cycle 2 raise req_i[0]; sel_o stays 0010. Then ready_i=1 -> gnt_o=0010, and the next winner is requester 2.
- NumIn=3 with req_i=3'b111 and ready_i=1 -> idx_o = 0, 1, 2, 0; rr_q never equals 3.
- Apply flush_i=1 while in LOCK holding index 2 -> the next cycle is unlocked, rr_q=0, and with req_i=4'b1111 the winner is 0. Repeat with rst_i for the same result.
- req_i=0 -> valid_o=0, sel_o=0, idx_o=0, gnt_o=0, and rr_q unchanged over 5 cycles.
